traffic_input_conditioner: RTL and testbench

Front-end stage that sits directly upstream of the traffic light controller and produces its vehicle-sensor and pedestrian-button inputs. It takes raw, asynchronous loop-detector and push-button signals and synchronizes and debounces them. Vehicle presence is stretched across short detection gaps. Pedestrian presses are latched as requests until the controller shows the matching walk signal. Stuck-high vehicle sensors are flagged for maintenance.

---
 rtl/traffic_input_conditioner.sv | 188 ++++++++++++++++++
 tb/tb_traffic_input_conditioner.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_input_conditioner.sv
// Input conditioner for the traffic light controller. It synchronizes and debounces the raw loop
// detectors and push buttons, stretches vehicle presence, latches pedestrian requests and flags stuck sensors.
module traffic_input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PRESENCE_HOLD   = 8,
    parameter int STUCK_CYCLES    = 200
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       N_raw,
    input  logic       S_raw,
    input  logic       E_raw,
    input  logic       W_raw,
    input  logic       NS_ped_raw,
    input  logic       EW_ped_raw,
    input  logic       NS_ped_served,
    input  logic       EW_ped_served,
    output logic       N_Sensor,
    output logic       S_Sensor,
    output logic       E_Sensor,
    output logic       W_Sensor,
    output logic       NS_pedestrian_button,
    output logic       EW_pedestrian_button,
    output logic [3:0] sensor_fault
);

    localparam int NCH    = 6;
    localparam int NVEH   = 4;
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = (PRESENCE_HOLD > 0) ? $clog2(PRESENCE_HOLD + 1) : 1;
    localparam int STK_W  = $clog2(STUCK_CYCLES + 1);

    localparam logic [DB_W-1:0]   DB_MAX    = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(PRESENCE_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);
    localparam logic [STK_W-1:0]  STK_MAX   = STK_W'(STUCK_CYCLES);
    localparam logic [STK_W-1:0]  STK_ONE   = STK_W'(1);
    localparam logic [STK_W-1:0]  STK_ZERO  = STK_W'(0);

    // Channels 3..0 are vehicles N,S,E,W (matching sensor_fault), 4 = NS button, 5 = EW button.
    logic [NCH-1:0] raw_s;
    logic [1:0]     served_s;

    assign raw_s    = {EW_ped_raw, NS_ped_raw, N_raw, S_raw, E_raw, W_raw};
    assign served_s = {EW_ped_served, NS_ped_served};

    logic [SYNC_STAGES-1:0] sync_q [NCH];
    logic [SYNC_STAGES-1:0] sync_d [NCH];
    logic [NCH-1:0]         sync_s;

    logic [NCH-1:0]         db_q;
    logic [NCH-1:0]         db_d;
    logic [DB_W-1:0]        dbc_q  [NCH];
    logic [DB_W-1:0]        dbc_d  [NCH];

    logic [HOLD_W-1:0]      hold_q [NVEH];
    logic [HOLD_W-1:0]      hold_d [NVEH];
    logic [NVEH-1:0]        veh_q;
    logic [NVEH-1:0]        veh_d;

    logic [STK_W-1:0]       stk_q  [NVEH];
    logic [STK_W-1:0]       stk_d  [NVEH];
    logic [NVEH-1:0]        fault_q;
    logic [NVEH-1:0]        fault_d;

    logic [1:0]             req_q;
    logic [1:0]             req_d;

    // Synchronizer shift chains; the last stage feeds the debouncer.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], raw_s[i]};
            sync_s[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    // Debouncer: the value flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < NCH; i++) begin
            dbc_d[i] = {DB_W{1'b0}};
            if (sync_s[i] == db_q[i]) begin
                dbc_d[i] = {DB_W{1'b0}};
            end else if ((dbc_q[i] + DB_ONE) == DB_MAX) begin
                db_d[i]  = ~db_q[i];
                dbc_d[i] = {DB_W{1'b0}};
            end else begin
                dbc_d[i] = dbc_q[i] + DB_ONE;
            end
        end
    end

    // Presence stretch: a debounced fall starts the hold; a re-rise during it cancels the drop.
    always_comb begin
        veh_d = veh_q;
        for (int v = 0; v < NVEH; v++) begin
            hold_d[v] = HOLD_ZERO;
            if (db_d[v]) begin
                hold_d[v] = HOLD_ZERO;
                veh_d[v]  = 1'b1;
            end else if (db_q[v]) begin
                hold_d[v] = HOLD_LOAD;
                veh_d[v]  = (HOLD_LOAD != HOLD_ZERO);
            end else if (hold_q[v] != HOLD_ZERO) begin
                hold_d[v] = hold_q[v] - HOLD_ONE;
                veh_d[v]  = (hold_q[v] != HOLD_ONE);
            end else begin
                hold_d[v] = HOLD_ZERO;
                veh_d[v]  = 1'b0;
            end
        end
    end

    // Stuck-high detection counts completed debounced-high cycles; the fault flag never self-clears.
    always_comb begin
        fault_d = fault_q;
        for (int v = 0; v < NVEH; v++) begin
            stk_d[v] = STK_ZERO;
            if (db_q[v]) begin
                if (stk_q[v] != STK_MAX) begin
                    stk_d[v] = stk_q[v] + STK_ONE;
                end else begin
                    stk_d[v] = stk_q[v];
                end
            end else begin
                stk_d[v] = STK_ZERO;
            end
            fault_d[v] = fault_q[v] | (stk_d[v] == STK_MAX);
        end
    end

    // Pedestrian latch: served has priority, so a press coinciding with the walk counts as served.
    always_comb begin
        req_d = req_q;
        for (int p = 0; p < 2; p++) begin
            if (served_s[p]) begin
                req_d[p] = 1'b0;
            end else if (db_d[NVEH+p] && !db_q[NVEH+p]) begin
                req_d[p] = 1'b1;
            end else begin
                req_d[p] = req_q[p];
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NCH; i++) begin
                sync_q[i] <= {SYNC_STAGES{1'b0}};
                dbc_q[i]  <= {DB_W{1'b0}};
            end
            for (int v = 0; v < NVEH; v++) begin
                hold_q[v] <= HOLD_ZERO;
                stk_q[v]  <= STK_ZERO;
            end
            db_q    <= {NCH{1'b0}};
            veh_q   <= {NVEH{1'b0}};
            fault_q <= {NVEH{1'b0}};
            req_q   <= 2'b00;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                sync_q[i] <= sync_d[i];
                dbc_q[i]  <= dbc_d[i];
            end
            for (int v = 0; v < NVEH; v++) begin
                hold_q[v] <= hold_d[v];
                stk_q[v]  <= stk_d[v];
            end
            db_q    <= db_d;
            veh_q   <= veh_d;
            fault_q <= fault_d;
            req_q   <= req_d;
        end
    end

    assign N_Sensor             = veh_q[3];
    assign S_Sensor             = veh_q[2];
    assign E_Sensor             = veh_q[1];
    assign W_Sensor             = veh_q[0];
    assign NS_pedestrian_button = req_q[0];
    assign EW_pedestrian_button = req_q[1];
    assign sensor_fault         = fault_q;

endmodule

// File: tb/tb_traffic_input_conditioner.sv
// Scoreboard bench for traffic_input_conditioner: directed stimulus queues edge-tagged expected bits,
// a monitor compares them against the outputs just after each rising edge.
module tb_traffic_input_conditioner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    logic N_raw, S_raw, E_raw, W_raw, NS_ped_raw, EW_ped_raw;
    logic NS_ped_served, EW_ped_served;
    logic N_Sensor, S_Sensor, E_Sensor, W_Sensor;
    logic NS_pedestrian_button, EW_pedestrian_button;
    logic [3:0] sensor_fault;

    traffic_input_conditioner dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .N_raw                (N_raw),
        .S_raw                (S_raw),
        .E_raw                (E_raw),
        .W_raw                (W_raw),
        .NS_ped_raw           (NS_ped_raw),
        .EW_ped_raw           (EW_ped_raw),
        .NS_ped_served        (NS_ped_served),
        .EW_ped_served        (EW_ped_served),
        .N_Sensor             (N_Sensor),
        .S_Sensor             (S_Sensor),
        .E_Sensor             (E_Sensor),
        .W_Sensor             (W_Sensor),
        .NS_pedestrian_button (NS_pedestrian_button),
        .EW_pedestrian_button (EW_pedestrian_button),
        .sensor_fault         (sensor_fault)
    );

    localparam int B_N = 9, B_S = 8, B_E = 7, B_W = 6, B_NSP = 5, B_EWP = 4, B_FN = 3, B_FW = 0;

    logic [9:0] out_s;
    assign out_s = {N_Sensor, S_Sensor, E_Sensor, W_Sensor,
                    NS_pedestrian_button, EW_pedestrian_button, sensor_fault};

    typedef struct {
        int    e;
        int    bitn;
        logic  val;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   errors   = 0;
    int   checks   = 0;
    int   edge_cnt = 0;

    task automatic expect_bit(input int e, input int b, input logic v, input string tag);
        exp_t x;
        x.e = e; x.bitn = b; x.val = v; x.tag = tag;
        sb.push_back(x);
    endtask

    task automatic direct_check(input string tag, input logic [9:0] want);
        checks++;
        if (out_s !== want) begin
            errors++;
            $display("FAIL %s: got %b, expected %b", tag, out_s, want);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: counts rising edges and checks every expectation due at this edge.
    initial begin : monitor
        forever begin
            @(posedge clk);
            edge_cnt++;
            #1;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].e <= edge_cnt) begin
                    checks++;
                    if (sb[i].e < edge_cnt) begin
                        errors++;
                        $display("FAIL %s: expectation for edge %0d missed (now %0d)", sb[i].tag, sb[i].e, edge_cnt);
                    end else if (out_s[sb[i].bitn] !== sb[i].val) begin
                        errors++;
                        $display("FAIL %s @edge %0d: got %b, expected %b", sb[i].tag, sb[i].e,
                                 out_s[sb[i].bitn], sb[i].val);
                    end
                    sb.delete(i);
                end
            end
        end
    end

    initial begin : stimulus
        int k, k2;
        reset_n = 1'b0;
        {N_raw, S_raw, E_raw, W_raw, NS_ped_raw, EW_ped_raw} = 6'b000000;
        {NS_ped_served, EW_ped_served} = 2'b00;
        #2;
        direct_check("reset_init", 10'b0000000000);
        step(3);
        reset_n = 1'b1;
        step(5);

        // 3-cycle glitch must be filtered
        k = edge_cnt + 1;
        N_raw = 1'b1;
        for (int j = 3; j <= 8; j++) expect_bit(k + j, B_N, 1'b0, "glitch_N");
        step(3);
        N_raw = 1'b0;
        step(15);

        // 10-cycle hold: rise after 6 edges, fall 14 edges after release
        k = edge_cnt + 1;
        N_raw = 1'b1;
        expect_bit(k + 4, B_N, 1'b0, "deb_N_before");
        expect_bit(k + 5, B_N, 1'b1, "deb_N_rise");
        expect_bit(k + 9, B_N, 1'b1, "deb_N_held");
        expect_bit(k + 22, B_N, 1'b1, "hold_N_last");
        expect_bit(k + 23, B_N, 1'b0, "hold_N_drop");
        step(10);
        N_raw = 1'b0;
        step(30);

        // E presence hold
        k = edge_cnt + 1;
        E_raw = 1'b1;
        expect_bit(k + 5, B_E, 1'b1, "hold_E_rise");
        step(20);
        k2 = edge_cnt + 1;
        E_raw = 1'b0;
        expect_bit(k2 + 12, B_E, 1'b1, "hold_E_last");
        expect_bit(k2 + 13, B_E, 1'b0, "hold_E_drop");
        step(25);

        // E re-raised during the hold never drops
        E_raw = 1'b1;
        step(20);
        k = edge_cnt + 1;
        E_raw = 1'b0;
        for (int j = 4; j <= 16; j++) expect_bit(k + j, B_E, 1'b1, "rerise_E");
        step(7);
        E_raw = 1'b1;
        step(10);
        k2 = edge_cnt + 1;
        E_raw = 1'b0;
        expect_bit(k2 + 12, B_E, 1'b1, "rerise_E_last");
        expect_bit(k2 + 13, B_E, 1'b0, "rerise_E_drop");
        step(25);

        // NS press latches, served clears next edge
        k = edge_cnt + 1;
        NS_ped_raw = 1'b1;
        expect_bit(k + 4, B_NSP, 1'b0, "ped_NS_before");
        expect_bit(k + 5, B_NSP, 1'b1, "ped_NS_set");
        expect_bit(k + 15, B_NSP, 1'b1, "ped_NS_latched");
        step(6);
        NS_ped_raw = 1'b0;
        step(14);
        k2 = edge_cnt + 1;
        NS_ped_served = 1'b1;
        expect_bit(k2, B_NSP, 1'b0, "ped_NS_clear");
        expect_bit(k2 + 3, B_NSP, 1'b0, "ped_NS_cleared");
        step(1);
        NS_ped_served = 1'b0;
        step(10);

        // press and served coincident: request stays 0, held button does not re-request
        k = edge_cnt + 1;
        NS_ped_raw = 1'b1;
        expect_bit(k + 5, B_NSP, 1'b0, "ped_coinc_5");
        expect_bit(k + 6, B_NSP, 1'b0, "ped_coinc_6");
        expect_bit(k + 9, B_NSP, 1'b0, "ped_coinc_held");
        step(5);
        NS_ped_served = 1'b1;
        step(1);
        NS_ped_served = 1'b0;
        step(5);
        NS_ped_raw = 1'b0;
        step(15);

        // W stuck high for 250 cycles
        k = edge_cnt + 1;
        W_raw = 1'b1;
        expect_bit(k + 5, B_W, 1'b1, "stuck_W_rise");
        expect_bit(k + 204, B_FW, 1'b0, "stuck_fault_early");
        expect_bit(k + 205, B_FW, 1'b1, "stuck_fault_set");
        expect_bit(k + 205, B_W, 1'b1, "stuck_W_not_forced");
        step(250);
        k2 = edge_cnt + 1;
        W_raw = 1'b0;
        expect_bit(k2 + 12, B_W, 1'b1, "stuck_W_last");
        expect_bit(k2 + 13, B_W, 1'b0, "stuck_W_drop");
        expect_bit(k2 + 20, B_FW, 1'b1, "stuck_fault_sticky");
        step(30);

        // independence: distinct patterns on all channels
        k = edge_cnt + 1;
        {N_raw, S_raw, NS_ped_raw, EW_ped_raw} = 4'b1111;
        expect_bit(k + 5, B_N, 1'b1, "ind_N_rise");
        expect_bit(k + 20, B_N, 1'b1, "ind_N_last");
        expect_bit(k + 21, B_N, 1'b0, "ind_N_drop");
        for (int j = 4; j <= 8; j++) expect_bit(k + j, B_S, 1'b0, "ind_S_glitch");
        expect_bit(k + 10, B_E, 1'b0, "ind_E_idle");
        expect_bit(k + 10, B_W, 1'b0, "ind_W_idle");
        expect_bit(k + 10, B_FW, 1'b1, "ind_fault_W");
        expect_bit(k + 10, B_FN, 1'b0, "ind_fault_N");
        expect_bit(k + 5, B_NSP, 1'b1, "ind_NS_set");
        expect_bit(k + 19, B_NSP, 1'b1, "ind_NS_hold");
        expect_bit(k + 20, B_NSP, 1'b0, "ind_NS_clear");
        expect_bit(k + 25, B_NSP, 1'b0, "ind_NS_cleared");
        expect_bit(k + 5, B_EWP, 1'b0, "ind_EW_glitch");
        expect_bit(k + 14, B_EWP, 1'b0, "ind_EW_before");
        expect_bit(k + 15, B_EWP, 1'b1, "ind_EW_set");
        expect_bit(k + 21, B_EWP, 1'b1, "ind_EW_not_NS_cleared");
        expect_bit(k + 22, B_EWP, 1'b0, "ind_EW_clear");
        expect_bit(k + 25, B_EWP, 1'b0, "ind_EW_cleared");
        step(2);
        EW_ped_raw = 1'b0;
        step(1);
        S_raw = 1'b0;
        step(2);
        NS_ped_raw = 1'b0;
        step(3);
        N_raw = 1'b0;
        step(2);
        EW_ped_raw = 1'b1;
        step(4);
        EW_ped_raw = 1'b0;
        step(6);
        NS_ped_served = 1'b1;
        step(1);
        NS_ped_served = 1'b0;
        step(1);
        EW_ped_served = 1'b1;
        step(1);
        EW_ped_served = 1'b0;
        step(20);

        // asynchronous reset mid-run with every raw input high
        k = edge_cnt + 1;
        {N_raw, S_raw, E_raw, W_raw, NS_ped_raw, EW_ped_raw} = 6'b111111;
        expect_bit(k + 5, B_S, 1'b1, "pre_reset_S");
        expect_bit(k + 5, B_EWP, 1'b1, "pre_reset_EW");
        expect_bit(k + 5, B_FW, 1'b1, "pre_reset_fault");
        step(8);
        #1;
        reset_n = 1'b0;
        #1;
        direct_check("reset_async", 10'b0000000000);
        step(2);
        {N_raw, S_raw, E_raw, W_raw, NS_ped_raw, EW_ped_raw} = 6'b000000;
        step(1);
        reset_n = 1'b1;
        step(10);
        direct_check("reset_release", 10'b0000000000);

        for (int j = 0; j < 40 && sb.size() > 0; j++) step(1);
        while (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s: expectation for edge %0d never checked", sb[0].tag, sb[0].e);
            sb.delete(0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
